// File: rtl/cshm_fir_pkg.sv
// Shared definitions for the serial CSHM FIR sequencer: FSM encoding,
// default datapath widths and a constant-foldable clog2.
package cshm_fir_pkg;

  localparam int XW_DEF = 12;  // sample width
  localparam int CW_DEF = 8;   // coefficient width
  localparam int PW_DEF = 16;  // multiplier product width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cshm_coef_regfile.sv
// Coefficient register file: NTAPS signed entries, one synchronous write
// port, one combinational read port, cleared by the asynchronous reset.
module cshm_coef_regfile
  import cshm_fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int CW    = CW_DEF,
  localparam int IW   = clog2(NTAPS)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 we,
  input  logic [IW-1:0]        waddr,
  input  logic signed [CW-1:0] wdata,
  input  logic [IW-1:0]        raddr,
  output logic signed [CW-1:0] rdata
);

  logic signed [CW-1:0] coef_q [NTAPS];
  logic signed [CW-1:0] coef_d [NTAPS];

  // Next-state: hold every entry, overwrite the addressed one on a write.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no path leaves it unassigned (which would infer a latch).
    coef_d = coef_q;
    if (we) begin
      coef_d[waddr] = wdata;
    end
  end

  // Storage; coefficients are architecturally zero after reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      // NOTE: this array is cleared on reset on purpose -- the filter must produce zero output until it is programmed, so it is built from flops rather than a RAM macro.
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      coef_q <= coef_d;
    end
  end

  assign rdata = coef_q[raddr];

endmodule

// File: rtl/cshm_fir_sequencer.sv
// Serial FIR controller: one CSHM multiplier is time-shared over all taps.
// Accepts a sample, walks idx over the delay line / coefficient pairs while
// accumulating products, then holds the result until the sink takes it.
module cshm_fir_sequencer
  import cshm_fir_pkg::*;
#(
  parameter int NTAPS = 8,
  parameter int XW    = XW_DEF,
  parameter int CW    = CW_DEF,
  parameter int PW    = PW_DEF,
  localparam int IW   = clog2(NTAPS),
  localparam int AW   = PW + IW
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [XW-1:0] in_data,
  input  logic                 cfg_we,
  input  logic [IW-1:0]        cfg_addr,
  input  logic signed [CW-1:0] cfg_data,
  output logic                 cfg_err,
  output logic signed [XW-1:0] mul_x,
  output logic signed [CW-1:0] mul_coeff,
  input  logic signed [PW-1:0] mul_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_data,
  output logic                 busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(NTAPS - 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [XW-1:0] x_q [NTAPS];
  logic signed [XW-1:0] x_d [NTAPS];
  logic                 cfg_err_q, cfg_err_d;
  logic signed [CW-1:0] coef_rd;
  logic                 addr_ok;
  logic                 cfg_ok;

  // Addresses past the last tap only exist when NTAPS is not a power of 2.
  if ((1 << IW) == NTAPS) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_check
    assign addr_ok = ({1'b0, cfg_addr} < (IW + 1)'(NTAPS));
  end

  // A write lands only while idle and not competing with a sample accept.
  assign cfg_ok = cfg_we && (state_q == ST_IDLE) && !in_valid && addr_ok;

  cshm_coef_regfile #(
    .NTAPS (NTAPS),
    .CW    (CW)
  ) u_coef (
    .clk    (clk),
    .resetn (resetn),
    .we     (cfg_ok),
    .waddr  (cfg_addr),
    .wdata  (cfg_data),
    .raddr  (idx_q),
    .rdata  (coef_rd)
  );

  // FSM next-state, delay-line shift, MAC datapath and multiplier operands.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    x_d       = x_q;
    cfg_err_d = cfg_we && !cfg_ok;
    mul_x     = '0;
    mul_coeff = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          x_d[0] = in_data;
          for (int k = 1; k < NTAPS; k++) begin
            x_d[k] = x_q[k-1];
          end
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_MAC;
        end
      end
      ST_MAC: begin
        mul_x     = x_q[idx_q];
        mul_coeff = coef_rd;
        acc_d     = acc_q + {{IW{mul_product[PW-1]}}, mul_product};
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any computation in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      acc_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        x_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      cfg_err_q <= cfg_err_d;
      x_q       <= x_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = (state_q == ST_DONE) ? acc_q : '0;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_cshm_fir_sequencer.sv
// Self-checking bench for cshm_fir_sequencer: a reference convolution model
// pushes expected outputs into a scoreboard when samples are accepted, and
// they are popped and compared on each output handshake.
module tb_cshm_fir_sequencer;

  localparam int NTAPS = 8;
  localparam int XW    = 12;
  localparam int CW    = 8;
  localparam int PW    = 16;
  localparam int IW    = 3;
  localparam int AW    = PW + IW;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [XW-1:0] in_data = '0;
  logic                 cfg_we = 1'b0;
  logic [IW-1:0]        cfg_addr = '0;
  logic signed [CW-1:0] cfg_data = '0;
  logic                 cfg_err;
  logic signed [XW-1:0] mul_x;
  logic signed [CW-1:0] mul_coeff;
  logic signed [PW-1:0] mul_product;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] out_data;
  logic                 busy;

  always #5 clk = ~clk;

  // Multiplier stand-in: full product truncated to the product width.
  int prod;
  assign prod        = int'(mul_x) * int'(mul_coeff);
  assign mul_product = prod[PW-1:0];

  cshm_fir_sequencer #(
    .NTAPS (NTAPS),
    .XW    (XW),
    .CW    (CW),
    .PW    (PW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_err     (cfg_err),
    .mul_x       (mul_x),
    .mul_coeff   (mul_coeff),
    .mul_product (mul_product),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  int     n_vec  = 0;
  int     n_miss = 0;
  int     cyc    = 0;
  int     m_coef [NTAPS];
  int     m_x    [NTAPS];
  longint sb [$];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference FIR: sum of truncated products, newest sample at tap 0.
  function automatic longint model_out();
    longint acc;
    int p;
    logic signed [PW-1:0] p16;
    acc = 0;
    for (int k = 0; k < NTAPS; k++) begin
      p   = m_x[k] * m_coef[k];
      p16 = p[PW-1:0];
      acc += longint'(p16);
    end
    return acc;
  endfunction

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!resetn) begin
      for (int k = 0; k < NTAPS; k++) begin
        m_coef[k] = 0;
        m_x[k]    = 0;
      end
      sb.delete();
    end else begin
      if (cfg_we && in_ready && !in_valid) begin
        m_coef[cfg_addr] = int'(cfg_data);
      end
      if (in_valid && in_ready) begin
        for (int k = NTAPS - 1; k > 0; k--) begin
          m_x[k] = m_x[k-1];
        end
        m_x[0] = int'(in_data);
        sb.push_back(model_out());
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          check("out_data", out_data, sb.pop_front());
        end
      end
    end
  end

  task automatic write_coef(input int a, input int v);
    cfg_we   = 1'b1;
    cfg_addr = a[IW-1:0];
    cfg_data = v[CW-1:0];
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_err_ok", cfg_err, 0);
  endtask

  task automatic send(input int s, output int acc_cyc);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    acc_cyc  = 0;
    in_data  = XW'(s);
    in_valid = 1'b1;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    if (busy) check(tag, busy, 0);
    @(posedge clk);
    #1;
    check({tag, "_drained"}, sb.size(), 0);
  endtask

  int  c0, c1, n, n_seen;
  bit  seen;
  longint v;

  initial begin
    // Reset state, both during and just after reset.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_mul_x", mul_x, 0);
    check("rst_mul_coeff", mul_coeff, 0);
    check("rst_cfg_err", cfg_err, 0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Impulse response with coef = 1..8, plus first-sample latency.
    for (int k = 0; k < NTAPS; k++) write_coef(k, k + 1);
    send(100, c0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      n++;
      seen = out_valid;
    end
    check("latency", n, NTAPS + 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < NTAPS - 1; i++) send(0, c1);
    wait_idle("impulse");

    // Step response with unit coefficients, plus throughput.
    for (int k = 0; k < NTAPS; k++) write_coef(k, 1);
    send(-5, c0);
    for (int i = 1; i < 10; i++) begin
      send(-5, c1);
      if (i == 1) check("throughput", c1 - c0, NTAPS + 2);
    end
    wait_idle("step");

    // Backpressure: result held, no new sample taken, then release.
    out_ready = 1'b0;
    send(7, c0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("bp_valid", out_valid, 1);
    v = (sb.size() > 0) ? sb[0] : 64'sd0;
    @(posedge clk);
    #1;
    in_data  = 12'sd3;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_stable", out_data, v);
      check("bp_in_ready", in_ready, 0);
      check("bp_valid_hold", out_valid, 1);
    end
    check("bp_mul_x", mul_x, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_busy", busy, 0);
    check("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle("bp");

    // Config write during MAC is rejected; so is one alongside a sample.
    send(11, c0);
    @(posedge clk);
    @(posedge clk);
    #1;
    cfg_we   = 1'b1;
    cfg_addr = 3'd2;
    cfg_data = 8'sd50;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check("cfg_err_mac", cfg_err, 1);
    @(posedge clk);
    #1;
    check("cfg_err_pulse", cfg_err, 0);
    wait_idle("cfg_mac");
    cfg_we   = 1'b1;
    cfg_addr = 3'd2;
    cfg_data = 8'sd50;
    send(2, c0);
    cfg_we = 1'b0;
    check("cfg_err_same", cfg_err, 1);
    wait_idle("cfg_same");

    // Reset during MAC: outputs clear, nothing emerges, coefficients zero.
    send(9, c0);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_mul_x", mul_x, 0);
    check("mrst_mul_coeff", mul_coeff, 0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) n_seen++;
    end
    check("mrst_no_valid", n_seen, 0);
    @(posedge clk);
    #1;
    send(100, c0);
    for (int i = 0; i < 3; i++) send(0, c1);
    wait_idle("mrst_impulse");

    // Extremes: largest-magnitude coefficient against +/-255.
    write_coef(0, -128);
    send(-255, c0);
    send(255, c1);
    wait_idle("extreme");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cshm_fir_sequencer.md
# cshm_fir_sequencer

- Serial FIR controller: time-multiplexes one CSHM multiplier (precomputer bank plus `select` stage) across all taps of an `NTAPS`-tap FIR filter.
- Owns the sample delay line and the coefficient register file, steps the tap index, and accumulates products.
- Sits between the sample source (valid/ready) and the filtered-output sink (valid/ready).
- Drives the multiplier's sample and coefficient inputs and consumes its product output.

## Interface
- `NTAPS`, 8, number of filter taps (≥2)
- `XW`, 12, sample width, signed
- `CW`, 8, coefficient width, signed
- `PW`, 16, multiplier product width, signed
- Derived localparams: `IW = clog2(NTAPS)`, `AW = PW + IW` (accumulator/output width)
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  reset, asynchronous, active-low
- `in_valid`  in  1  input sample valid
- `in_ready`  out  1  sequencer can accept a sample
- `in_data`  in  XW  input sample, signed
- `cfg_we`  in  1  coefficient write strobe
- `cfg_addr`  in  IW  coefficient index
- `cfg_data`  in  CW  coefficient value, signed
- `cfg_err`  out  1  one-cycle pulse: write rejected
- `mul_x`  out  XW  sample to precomputer bank
- `mul_coeff`  out  CW  coefficient to select stage
- `mul_product`  in  PW  product; combinational function of `mul_x`/`mul_coeff` in the same cycle
- `out_valid`  out  1  filtered sample valid
- `out_ready`  in  1  sink accepts
- `out_data`  out  AW  filtered sample, signed
- `busy`  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, shift the delay line (`x[0]←in_data`, `x[k]←x[k-1]`), clear the accumulator, set `idx←0`, and go to MAC.
  - MAC: drive `mul_x=x[idx]` and `mul_coeff=coef[idx]`, and update `acc←acc+sext(mul_product)`.
    - If `idx==NTAPS-1`, go to DONE; otherwise `idx←idx+1`.
  - DONE: `out_valid=1`, `out_data=acc` held stable. On `out_ready`, go to IDLE.
- Outside MAC, `mul_x` and `mul_coeff` are driven to 0.
- Arithmetic: products are sign-extended to `AW`. With `AW` bits the accumulator cannot overflow, so there is no saturation and no wrap.
- Config writes:
  - Accepted only in IDLE with `in_valid=0`. The write takes effect on the next edge.
  - `cfg_we` in any other state, or in the same cycle as an accepted sample, is dropped and `cfg_err` pulses for one cycle.
  - `cfg_addr ≥ NTAPS` (non-power-of-2 `NTAPS`) is dropped and `cfg_err` pulses.
- Coefficients and the delay line persist across samples. Only reset clears them.

## Timing
- Reset values:
  - State: IDLE, so `in_ready=1` during reset deassertion.
  - Outputs: `out_valid=0`, `out_data=0`, `cfg_err=0`, `busy=0`, `mul_x=0`, `mul_coeff=0`.
  - Internal: all coefficients 0, delay line 0, accumulator 0, `idx=0`.
- Latency: sample accepted at edge T. MAC occupies cycles T+1..T+NTAPS. `out_valid` rises at T+NTAPS+1.
- Throughput: one sample per `NTAPS+2` cycles with `out_ready` held high.
- `in_ready` is low in MAC and DONE. `out_valid`/`out_data` remain stable under backpressure until the handshake.
- Reset mid-MAC or mid-DONE: the computation is abandoned and no `out_valid` is produced. After release, the first output reflects only post-reset samples.

## Structure
- Shared package `cshm_fir_pkg`:
  - FSM state encoding (IDLE=0, MAC=1, DONE=2)
  - default widths `XW`, `CW`, `PW`
  - a clog2 function
- Sub-module `cshm_coef_regfile`: `NTAPS×CW` registers, one write port, one combinational read port indexed by `idx`, asynchronous clear.
- The delay line, FSM and accumulator live in the top level.

## Test plan
The bench multiplier model returns `mul_x*mul_coeff`.
- Impulse response: coef = {1,2,3,…,8}; feed 100, then seven 0s → outputs 100,200,…,800.
- Step: all coefs = 1; feed 8 samples of −5 → outputs −5,−10,…,−40, then steady at −40.
- Backpressure: `out_ready=0` for 10 cycles after `out_valid` → `out_data` stable, `in_ready=0`, no new sample accepted; release → IDLE one cycle later.
- Config during MAC: `cfg_we` at T+3 with addr 2 → `cfg_err` pulse, coef[2] unchanged in the next output.
- Reset at T+4 of MAC → all outputs 0 immediately, no `out_valid`, coefs read back as 0 via an impulse test.
- Extremes: coef[0]=−128, others 0; sample −255 → `out_data`=32640; sample 255 → −32640.
